// File: rtl/fp_vec_checker.sv
// ROM-driven vector sequencer/checker for start/done floating-point units.
// Define VEC_CHK_FLAGS_EN to also fail vectors whose DUT flags differ from the expected flags.
module fp_vec_checker #(
   parameter int WIDTH        = 64,
   parameter int FLAGW        = 5,
   parameter int ADDRW        = 16,
   parameter int START_CYCLES = 2,
   parameter int TIMEOUT      = 12
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   go,
   output logic [ADDRW-1:0]       vec_addr,
   input  logic [3*WIDTH+7:0]     vec_data,
   input  logic                   vec_valid,
   output logic [WIDTH-1:0]       dut_op1,
   output logic [WIDTH-1:0]       dut_op2,
   output logic                   dut_start,
   input  logic                   dut_done,
   input  logic [WIDTH-1:0]       dut_result,
   input  logic [FLAGW-1:0]       dut_flags,
   output logic                   busy,
   output logic                   finished,
   output logic                   mismatch,
   output logic [ADDRW-1:0]       fail_addr,
   output logic [ADDRW:0]         vec_count,
   output logic [15:0]            err_count,
   output logic [15:0]            timeout_count
);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, WAIT, CHECK, DONE} state_t;

   state_t             state, next_state;
   logic [15:0]        start_cnt;
   logic [15:0]        wait_cnt;
   logic [WIDTH-1:0]   exp_q;
   logic [7:0]         exp_flags_q;
   logic [WIDTH-1:0]   res_q;
   logic [FLAGW-1:0]   flags_q;
   logic               tmo_q;
   logic               fail;
   logic               start_last;
   logic               wait_last;
   logic               addr_last;
   logic               unused_flags;

   assign start_last = (start_cnt == 16'(START_CYCLES - 1));
   assign wait_last  = (wait_cnt == 16'(TIMEOUT - 1));
   assign addr_last  = (vec_addr == {ADDRW{1'b1}});

`ifdef VEC_CHK_FLAGS_EN
   assign fail = tmo_q || (res_q != exp_q) || (flags_q != exp_flags_q[FLAGW-1:0]);
`else
   assign fail = tmo_q || (res_q != exp_q);
`endif

   // Upper expected-flag bits (and, without flag checking, all flag state) have no consumer.
   assign unused_flags = ^{exp_flags_q, flags_q};

   assign dut_start = (state == START);
   assign busy      = (state == FETCH) || (state == LOAD) || (state == START) ||
                      (state == WAIT)  || (state == CHECK);
   assign finished  = (state == DONE);

   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: if (go) next_state = FETCH;
         FETCH:      next_state = LOAD;
         LOAD:       next_state = vec_valid ? START : DONE;
         START:      if (start_last) next_state = WAIT;
         WAIT:       if (dut_done || wait_last) next_state = CHECK;
         CHECK:      next_state = addr_last ? DONE : FETCH;
         default:    next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         start_cnt     <= '0;
         wait_cnt      <= '0;
         vec_addr      <= '0;
         dut_op1       <= '0;
         dut_op2       <= '0;
         exp_q         <= '0;
         exp_flags_q   <= '0;
         res_q         <= '0;
         flags_q       <= '0;
         tmo_q         <= 1'b0;
         mismatch      <= 1'b0;
         fail_addr     <= '0;
         vec_count     <= '0;
         err_count     <= '0;
         timeout_count <= '0;
      end else begin
         state    <= next_state;
         mismatch <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (go) begin
                  vec_addr      <= '0;
                  fail_addr     <= '0;
                  vec_count     <= '0;
                  err_count     <= '0;
                  timeout_count <= '0;
               end
            end
            LOAD: begin
               start_cnt <= '0;
               if (vec_valid) begin
                  dut_op1     <= vec_data[3*WIDTH+7:2*WIDTH+8];
                  dut_op2     <= vec_data[2*WIDTH+7:WIDTH+8];
                  exp_q       <= vec_data[WIDTH+7:8];
                  exp_flags_q <= vec_data[7:0];
               end
            end
            START: begin
               start_cnt <= start_cnt + 16'd1;
               wait_cnt  <= '0;
            end
            WAIT: begin
               wait_cnt <= wait_cnt + 16'd1;
               // Done in the expiry cycle wins over the timeout.
               if (dut_done) begin
                  res_q   <= dut_result;
                  flags_q <= dut_flags;
                  tmo_q   <= 1'b0;
               end else if (wait_last) begin
                  tmo_q   <= 1'b1;
               end
            end
            CHECK: begin
               vec_count <= vec_count + 1'b1;
               if (fail) begin
                  mismatch  <= 1'b1;
                  fail_addr <= vec_addr;
                  if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                  if (tmo_q && (timeout_count != 16'hFFFF)) timeout_count <= timeout_count + 16'd1;
               end
               if (!addr_last) vec_addr <= vec_addr + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_vec_checker.sv
// Scoreboard bench for fp_vec_checker: ROM and iterative-DUT models, randomized vector plans.
module tb_fp_vec_checker;
   localparam int WIDTH = 64;
   localparam int FLAGW = 5;
   localparam int ADDRW = 2;
   localparam int SC    = 2;
   localparam int TO    = 12;
   localparam int NV    = 4;

   logic                 clk;
   logic                 reset;
   logic                 go;
   logic [ADDRW-1:0]     vec_addr;
   logic [3*WIDTH+7:0]   vec_data;
   logic                 vec_valid;
   logic [WIDTH-1:0]     dut_op1, dut_op2;
   logic                 dut_start;
   logic                 dut_done;
   logic [WIDTH-1:0]     dut_result;
   logic [FLAGW-1:0]     dut_flags;
   logic                 busy, finished, mismatch;
   logic [ADDRW-1:0]     fail_addr;
   logic [ADDRW:0]       vec_count;
   logic [15:0]          err_count, timeout_count;

   fp_vec_checker #(.WIDTH(WIDTH), .FLAGW(FLAGW), .ADDRW(ADDRW),
                    .START_CYCLES(SC), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .go(go), .vec_addr(vec_addr), .vec_data(vec_data),
      .vec_valid(vec_valid), .dut_op1(dut_op1), .dut_op2(dut_op2), .dut_start(dut_start),
      .dut_done(dut_done), .dut_result(dut_result), .dut_flags(dut_flags), .busy(busy),
      .finished(finished), .mismatch(mismatch), .fail_addr(fail_addr), .vec_count(vec_count),
      .err_count(err_count), .timeout_count(timeout_count));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vector plan: ROM contents plus how the modelled divider behaves on each entry.
   logic [WIDTH-1:0] op1_m[NV], op2_m[NV], exp_m[NV];
   logic [7:0]       fexp_m[NV];
   logic [FLAGW-1:0] fdut_m[NV];
   int               lat_m[NV];
   bit               never_m[NV], bad_m[NV];
   int               nvalid = 0;
   bit               spurious = 0;
   bit               mon_en = 0;

   typedef struct { logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; } ops_t;
   typedef struct { int addr; int errc; } fail_t;
   ops_t  exp_ops[$];
   fail_t exp_fail[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Synchronous ROM: data one cycle after the address.
   always @(posedge clk) begin
      vec_data  <= {op1_m[vec_addr], op2_m[vec_addr], exp_m[vec_addr], fexp_m[vec_addr]};
      vec_valid <= (int'(vec_addr) < nvalid);
   end

   // Iterative-unit model: done arrives lat cycles into WAIT, or never.
   bit             start_q = 0;
   bit             armed = 0;
   int             wcnt = 0;
   logic [ADDRW-1:0] cur = '0;
   initial begin
      dut_done   = 1'b0;
      dut_result = '0;
      dut_flags  = '0;
   end
   always @(negedge clk) begin
      dut_done = 1'b0;
      if (dut_start && spurious && ($urandom_range(0, 1) == 1)) begin
         dut_done   = 1'b1;
         dut_result = {$urandom, $urandom};
         dut_flags  = FLAGW'($urandom);
      end
      if (start_q && !dut_start && busy && !never_m[vec_addr]) begin
         armed = 1;
         wcnt  = 0;
         cur   = vec_addr;
      end
      if (armed) begin
         if (wcnt == lat_m[cur] - 1) begin
            dut_done   = 1'b1;
            dut_result = exp_m[cur] + (bad_m[cur] ? 64'd1 : 64'd0);
            dut_flags  = fdut_m[cur];
            armed      = 0;
         end else begin
            wcnt++;
         end
      end
      start_q = dut_start;
   end

   // Monitor: pops expectations when operands are launched and when a mismatch pulses.
   bit mstart_q = 0;
   always @(negedge clk) begin
      if (mon_en) begin
         if (dut_start && !mstart_q) begin
            if (exp_ops.size() == 0) check("unexpected_start", 64'd1, 64'd0);
            else begin
               ops_t e;
               e = exp_ops.pop_front();
               check("dut_op1", dut_op1, e.a);
               check("dut_op2", dut_op2, e.b);
            end
         end
         if (mismatch) begin
            if (exp_fail.size() == 0) check("unexpected_mismatch", 64'd1, 64'd0);
            else begin
               fail_t f;
               f = exp_fail.pop_front();
               check("fail_addr_pulse", 64'(fail_addr), 64'(f.addr));
               check("err_count_pulse", 64'(err_count), 64'(f.errc));
            end
         end
      end
      mstart_q = dut_start;
   end

   task automatic plan_random();
      for (int i = 0; i < NV; i++) begin
         op1_m[i]  = {$urandom, $urandom};
         op2_m[i]  = {$urandom, $urandom};
         exp_m[i]  = {$urandom, $urandom};
         fexp_m[i] = 8'($urandom_range(0, 255));
         lat_m[i]  = $urandom_range(1, TO);
         never_m[i] = ($urandom_range(0, 5) == 0);
         bad_m[i]   = ($urandom_range(0, 3) == 0);
         fdut_m[i]  = ($urandom_range(0, 3) == 0) ? FLAGW'($urandom) : fexp_m[i][FLAGW-1:0];
      end
   endtask

   task automatic plan_clean(input int lat);
      plan_random();
      for (int i = 0; i < NV; i++) begin
         lat_m[i] = lat; never_m[i] = 0; bad_m[i] = 0; fdut_m[i] = fexp_m[i][FLAGW-1:0];
      end
   endtask

   task automatic run(input int nv, input bit spur, input bit gobusy);
      int total, errs, tmos, last_fail, edges, w;
      bit f;
      total = 0; errs = 0; tmos = 0; last_fail = 0;
      nvalid = nv; spurious = spur;
      for (int i = 0; i < nv; i++) begin
         ops_t o;
         w = never_m[i] ? TO : lat_m[i];
         total += 3 + SC + w;
         f = never_m[i] || bad_m[i];
`ifdef VEC_CHK_FLAGS_EN
         if (fdut_m[i] != fexp_m[i][FLAGW-1:0]) f = 1;
`endif
         o.a = op1_m[i]; o.b = op2_m[i];
         exp_ops.push_back(o);
         if (f) begin
            fail_t fe;
            errs++;
            last_fail = i;
            fe.addr = i; fe.errc = errs;
            exp_fail.push_back(fe);
         end
         if (never_m[i]) tmos++;
      end
      if (nv < NV) total += 2;
      mon_en = 1;
      @(negedge clk) go = 1'b1;
      @(negedge clk) go = 1'b0;
      edges = 0;
      while (!finished && edges < 2000) begin
         go = gobusy && (edges == 7);
         @(negedge clk);
         edges++;
      end
      go = 1'b0;
      @(negedge clk);
      check("run_cycles", 64'(edges), 64'(total));
      check("finished", 64'(finished), 64'd1);
      check("busy_done", 64'(busy), 64'd0);
      check("vec_count", 64'(vec_count), 64'(nv));
      check("err_count", 64'(err_count), 64'(errs));
      check("timeout_count", 64'(timeout_count), 64'(tmos));
      check("fail_addr", 64'(fail_addr), 64'(last_fail));
      check("vec_addr_end", 64'(vec_addr), 64'((nv < NV) ? nv : NV - 1));
      check("ops_drained", 64'(exp_ops.size()), 64'd0);
      check("fails_drained", 64'(exp_fail.size()), 64'd0);
      exp_ops.delete();
      exp_fail.delete();
      spurious = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_vec_addr"}, 64'(vec_addr), 64'd0);
      check({tag, "_dut_op1"}, dut_op1, 64'd0);
      check({tag, "_dut_start"}, 64'(dut_start), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_finished"}, 64'(finished), 64'd0);
      check({tag, "_mismatch"}, 64'(mismatch), 64'd0);
      check({tag, "_counters"}, {vec_count, err_count, timeout_count, fail_addr}, 64'd0);
   endtask

   initial begin
      int guard;
      reset = 1'b0;
      go    = 1'b0;
      plan_clean(5);
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      check("reset_op2", dut_op2, 64'd0);
      reset = 1'b1;
      @(negedge clk);

      // Three clean vectors, 5-cycle divider: 10 cycles each.
      plan_clean(5);
      run(3, 0, 0);

      // Vector 1 one ULP off.
      plan_clean(5);
      bad_m[1] = 1;
      run(3, 0, 0);

      // Divider never answers.
      plan_clean(5);
      for (int i = 0; i < NV; i++) never_m[i] = 1;
      run(3, 0, 0);

      // Done exactly on the expiry cycle counts as done.
      plan_clean(TO);
      run(2, 0, 0);

      // Result correct, flags differ.
      plan_clean(3);
      fexp_m[0] = 8'h00;
      fdut_m[0] = 5'b00001;
      run(1, 0, 0);

      // Full address space: no wrap, then a rerun clears counters.
      plan_clean(2);
      bad_m[3] = 1;
      run(4, 0, 0);
      plan_clean(1);
      run(4, 0, 0);

      // Randomized runs with spurious done during START and go while busy.
      for (int r = 0; r < 12; r++) begin
         plan_random();
         run($urandom_range(2, NV), 1, 1);
      end

      // Reset during START aborts the run.
      plan_clean(3);
      bad_m[0] = 1;
      nvalid = 3;
      mon_en = 0;
      @(negedge clk) go = 1'b1;
      @(negedge clk) go = 1'b0;
      guard = 0;
      while (!(dut_start && vec_addr == 2'd1) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("pre_reset_in_start", 64'(dut_start && vec_addr == 2'd1), 64'd1);
      check("pre_reset_err", 64'(err_count), 64'd1);
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("abort");
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_after_abort", 64'(busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
